// File: rtl/mesm6_pic_pkg.sv
// Shared PIC definitions: register map, sequencer state encoding and the IFS clear-mask helper.
package mesm6_pic_pkg;

    localparam int NUM_IRQ_BITS = 48;
    localparam int PIC_ADDR_W   = 15;

    localparam logic [PIC_ADDR_W-1:0] ADDR_OFF    = 15'o0;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IFS    = 15'o1;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IFSSET = 15'o2;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IECSET = 15'o3;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IEC    = 15'o4;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IFSCLR = 15'o5;
    localparam logic [PIC_ADDR_W-1:0] ADDR_IECCLR = 15'o6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_H_WAIT = 3'd1,
        ST_S_RD   = 3'd2,
        ST_S_CLR  = 3'd3,
        ST_S_DLV  = 3'd4
    } seq_state_t;

    typedef enum logic {
        RR_HOST = 1'b0,
        RR_SEQ  = 1'b1
    } rr_t;

    // OFF value n maps to IFS bit (48-n); out-of-range offsets shift out to an all-zero mask.
    function automatic logic [NUM_IRQ_BITS-1:0] ifs_clr_mask(input logic [5:0] off);
        logic [6:0] sh;
        sh = 7'd48 - {1'b0, off};
        ifs_clr_mask = {{(NUM_IRQ_BITS-1){1'b0}}, 1'b1} << sh;
    endfunction

endpackage

// File: rtl/mesm6_irq_sync.sv
// Per-bit 2-FF synchroniser with registered rising-edge pulse (3 clocks from input rise).
module mesm6_irq_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_async,
    output logic [W-1:0] pulse
);

    logic [W-1:0] s1_q, s2_q, s3_q, pulse_q, pulse_d;

    // Edge detect on the synchronised level.
    always_comb begin
        pulse_d = s2_q & ~s3_q;
    end

    // Synchroniser chain and pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= {W{1'b0}};
            s2_q    <= {W{1'b0}};
            s3_q    <= {W{1'b0}};
            pulse_q <= {W{1'b0}};
        end else begin
            s1_q    <= d_async;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/mesm6_irq_seq.sv
// Interrupt-entry sequencer and PIC port arbiter between CPU and mesm6_pic.
// Define IRQ_SYNC_EN to synchronise raw asynchronous dev_irq lines into single pic_irq pulses.
module mesm6_irq_seq
    import mesm6_pic_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int SCNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    interrupt,
    input  logic                    cpu_int_en,
    output logic [5:0]              cpu_vec,
    output logic                    cpu_vec_valid,
    input  logic                    cpu_vec_ack,
    input  logic [PIC_ADDR_W-1:0]   host_addr,
    input  logic                    host_read,
    input  logic                    host_write,
    input  logic [NUM_IRQ_BITS-1:0] host_wdata,
    output logic [NUM_IRQ_BITS-1:0] host_rdata,
    output logic                    host_done,
    output logic [PIC_ADDR_W-1:0]   pic_addr,
    output logic                    pic_read,
    output logic                    pic_write,
    output logic [NUM_IRQ_BITS-1:0] pic_wdata,
    input  logic [NUM_IRQ_BITS-1:0] pic_rdata,
    input  logic                    pic_done,
    input  logic [1:0]              dev_irq,
    output logic [1:0]              pic_irq,
    output logic                    seq_err,
    output logic [SCNT_W-1:0]       spur_cnt
);

    localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_t              state_q, state_d;
    rr_t                     rr_q, rr_d;
    logic [WCNT_W-1:0]       wait_q, wait_d;
    logic [5:0]              off_q, off_d;
    logic [SCNT_W-1:0]       spur_cnt_q, spur_cnt_d;
    logic [5:0]              cpu_vec_q, cpu_vec_d;
    logic                    cpu_vec_valid_q, cpu_vec_valid_d;
    logic [NUM_IRQ_BITS-1:0] host_rdata_q, host_rdata_d;
    logic                    host_done_q, host_done_d;
    logic [PIC_ADDR_W-1:0]   pic_addr_q, pic_addr_d;
    logic [NUM_IRQ_BITS-1:0] pic_wdata_q, pic_wdata_d;
    logic                    pic_read_q, pic_read_d;
    logic                    pic_write_q, pic_write_d;
    logic                    seq_err_q, seq_err_d;

    logic       cand_s_s, cand_h_s, grant_h_s, grant_s_s, timeout_s;
    logic [5:0] rd_off_s;

    // A host request is masked during its own done cycle, before the CPU can drop the level.
    assign cand_s_s = interrupt & cpu_int_en & ~cpu_vec_valid_q;
    assign cand_h_s = (host_read | host_write) & ~host_done_q;

    // Next-state and next-output computation for the arbiter/sequencer.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        wait_d          = wait_q;
        off_d           = off_q;
        spur_cnt_d      = spur_cnt_q;
        cpu_vec_d       = cpu_vec_q;
        host_rdata_d    = host_rdata_q;
        host_done_d     = 1'b0;
        pic_addr_d      = pic_addr_q;
        pic_wdata_d     = pic_wdata_q;
        pic_read_d      = 1'b0;
        pic_write_d     = 1'b0;
        seq_err_d       = 1'b0;
        grant_h_s       = 1'b0;
        grant_s_s       = 1'b0;
        rd_off_s        = pic_rdata[5:0];
        timeout_s       = (wait_q == WCNT_W'(TIMEOUT - 1));

        if (cpu_vec_valid_q && cpu_vec_ack) begin
            cpu_vec_valid_d = 1'b0;
        end else begin
            cpu_vec_valid_d = cpu_vec_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cand_h_s && cand_s_s) begin
                    if (rr_q == RR_HOST) begin
                        grant_h_s = 1'b1;
                        rr_d      = RR_SEQ;
                    end else begin
                        grant_s_s = 1'b1;
                        rr_d      = RR_HOST;
                    end
                end else begin
                    grant_h_s = cand_h_s;
                    grant_s_s = cand_s_s;
                end
            end
            ST_H_WAIT: begin
                if (pic_done) begin
                    host_rdata_d = pic_rdata;
                    host_done_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else if (timeout_s) begin
                    host_rdata_d = {NUM_IRQ_BITS{1'b0}};
                    host_done_d  = 1'b1;
                    seq_err_d    = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ST_S_RD: begin
                if (pic_done) begin
                    if (rd_off_s == 6'd0) begin
                        if (spur_cnt_q != {SCNT_W{1'b1}}) begin
                            spur_cnt_d = spur_cnt_q + SCNT_W'(1);
                        end else begin
                            spur_cnt_d = spur_cnt_q;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        off_d       = rd_off_s;
                        pic_addr_d  = ADDR_IFSCLR;
                        pic_wdata_d = ifs_clr_mask(rd_off_s);
                        pic_write_d = 1'b1;
                        wait_d      = {WCNT_W{1'b0}};
                        state_d     = ST_S_CLR;
                    end
                end else if (timeout_s) begin
                    seq_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ST_S_CLR: begin
                if (pic_done) begin
                    cpu_vec_d       = off_q;
                    cpu_vec_valid_d = 1'b1;
                    state_d         = ST_S_DLV;
                end else if (timeout_s) begin
                    seq_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ST_S_DLV: begin
                // The vector stays valid across a host access; the ack is honoured in any state.
                if (cand_h_s) begin
                    grant_h_s = 1'b1;
                end else if (cpu_vec_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_S_DLV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_h_s) begin
            pic_addr_d  = host_addr;
            pic_wdata_d = host_wdata;
            pic_read_d  = host_read;
            pic_write_d = host_write & ~host_read;
            wait_d      = {WCNT_W{1'b0}};
            state_d     = ST_H_WAIT;
        end else if (grant_s_s) begin
            pic_addr_d = ADDR_OFF;
            pic_read_d = 1'b1;
            wait_d     = {WCNT_W{1'b0}};
            state_d    = ST_S_RD;
        end else begin
            pic_read_d = pic_read_d;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            rr_q            <= RR_HOST;
            wait_q          <= {WCNT_W{1'b0}};
            off_q           <= 6'd0;
            spur_cnt_q      <= {SCNT_W{1'b0}};
            cpu_vec_q       <= 6'd0;
            cpu_vec_valid_q <= 1'b0;
            host_rdata_q    <= {NUM_IRQ_BITS{1'b0}};
            host_done_q     <= 1'b0;
            pic_addr_q      <= {PIC_ADDR_W{1'b0}};
            pic_wdata_q     <= {NUM_IRQ_BITS{1'b0}};
            pic_read_q      <= 1'b0;
            pic_write_q     <= 1'b0;
            seq_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            wait_q          <= wait_d;
            off_q           <= off_d;
            spur_cnt_q      <= spur_cnt_d;
            cpu_vec_q       <= cpu_vec_d;
            cpu_vec_valid_q <= cpu_vec_valid_d;
            host_rdata_q    <= host_rdata_d;
            host_done_q     <= host_done_d;
            pic_addr_q      <= pic_addr_d;
            pic_wdata_q     <= pic_wdata_d;
            pic_read_q      <= pic_read_d;
            pic_write_q     <= pic_write_d;
            seq_err_q       <= seq_err_d;
        end
    end

    assign cpu_vec       = cpu_vec_q;
    assign cpu_vec_valid = cpu_vec_valid_q;
    assign host_rdata    = host_rdata_q;
    assign host_done     = host_done_q;
    assign pic_addr      = pic_addr_q;
    assign pic_wdata     = pic_wdata_q;
    assign pic_read      = pic_read_q;
    assign pic_write     = pic_write_q;
    assign seq_err       = seq_err_q;
    assign spur_cnt      = spur_cnt_q;

`ifdef IRQ_SYNC_EN
    mesm6_irq_sync #(.W(2)) u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_async (dev_irq),
        .pulse   (pic_irq)
    );
`else
    assign pic_irq = dev_irq;
`endif

endmodule

// File: tb/tb_mesm6_irq_seq.sv
// Scoreboard bench for mesm6_irq_seq with a small behavioural PIC responder.
module tb_mesm6_irq_seq;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        interrupt;
    logic        cpu_int_en;
    logic [5:0]  cpu_vec;
    logic        cpu_vec_valid;
    logic        cpu_vec_ack;
    logic [14:0] host_addr;
    logic        host_read;
    logic        host_write;
    logic [47:0] host_wdata;
    logic [47:0] host_rdata;
    logic        host_done;
    logic [14:0] pic_addr;
    logic        pic_read;
    logic        pic_write;
    logic [47:0] pic_wdata;
    logic [47:0] pic_rdata;
    logic        pic_done = 1'b0;
    logic [1:0]  dev_irq;
    logic [1:0]  pic_irq;
    logic        seq_err;
    logic [7:0]  spur_cnt;

    logic [47:0] ifs, iec;
    logic        stall;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_strobe = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [47:0] wdata;
    } pic_exp_t;

    pic_exp_t    pic_q[$];
    logic [47:0] host_q[$];
    logic [5:0]  vec_q[$];
    int          err_q[$];

    mesm6_irq_seq #(.TIMEOUT(TIMEOUT), .SCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .interrupt(interrupt), .cpu_int_en(cpu_int_en),
        .cpu_vec(cpu_vec), .cpu_vec_valid(cpu_vec_valid), .cpu_vec_ack(cpu_vec_ack),
        .host_addr(host_addr), .host_read(host_read), .host_write(host_write),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
        .pic_addr(pic_addr), .pic_read(pic_read), .pic_write(pic_write),
        .pic_wdata(pic_wdata), .pic_rdata(pic_rdata), .pic_done(pic_done),
        .dev_irq(dev_irq), .pic_irq(pic_irq), .seq_err(seq_err), .spur_cnt(spur_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] off_of(input logic [47:0] v);
        off_of = 6'd0;
        for (int i = 0; i < 48; i++) if (v[i]) off_of = 6'(48 - i);
    endfunction

    // PIC responder: combinational read data, done one cycle after each strobe.
    assign interrupt = |(ifs & iec);
    assign pic_rdata = (pic_addr == 15'o0) ? {42'd0, off_of(ifs & iec)} :
                       (pic_addr == 15'o1) ? ifs :
                       (pic_addr == 15'o4) ? iec : 48'd0;
    always @(posedge clk) pic_done <= (pic_read | pic_write) & ~stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_pic(input logic rd, input logic [14:0] addr, input logic [47:0] wdata);
        pic_exp_t e;
        e.rd = rd; e.wr = ~rd; e.addr = addr; e.wdata = wdata;
        pic_q.push_back(e);
    endtask

    task automatic wait_host_done(input string name);
        int n = 0;
        while (!host_done && n < 60) begin @(negedge clk); n++; end
        check({name, "_host_done_seen"}, host_done, 1'b1);
    endtask

    task automatic wait_vec_valid(input string name);
        int n = 0;
        while (!cpu_vec_valid && n < 60) begin @(negedge clk); n++; end
        check({name, "_vec_valid_seen"}, cpu_vec_valid, 1'b1);
    endtask

    task automatic ack_vec(input string name);
        cpu_vec_ack = 1'b1;
        @(negedge clk);
        cpu_vec_ack = 1'b0;
        check({name, "_valid_after_ack"}, cpu_vec_valid, 1'b0);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    initial begin : monitor
        pic_exp_t e;
        logic     vprev;
        int       tok;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pic_read | pic_write) begin
                    last_strobe = cyc;
                    check("pic_strobe_expected", pic_q.size() > 0, 1'b1);
                    if (pic_q.size() > 0) begin
                        e = pic_q.pop_front();
                        check("pic_kind", {pic_read, pic_write}, {e.rd, e.wr});
                        check("pic_addr", pic_addr, e.addr);
                        if (e.wr) check("pic_wdata", pic_wdata, e.wdata);
                    end
                end
                if (host_done) begin
                    check("host_done_expected", host_q.size() > 0, 1'b1);
                    if (host_q.size() > 0) check("host_rdata", host_rdata, host_q.pop_front());
                end
                if (cpu_vec_valid && !vprev) begin
                    check("vec_expected", vec_q.size() > 0, 1'b1);
                    if (vec_q.size() > 0) check("cpu_vec", cpu_vec, vec_q.pop_front());
                end
                if (seq_err) begin
                    check("seq_err_expected", err_q.size() > 0, 1'b1);
                    if (err_q.size() > 0) begin
                        tok = err_q.pop_front();
                        check("seq_err_latency", cyc - last_strobe, tok);
                    end
                end
            end
            vprev = cpu_vec_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        reset_n = 1'b0; cpu_int_en = 1'b0; cpu_vec_ack = 1'b0;
        host_addr = 15'd0; host_read = 1'b0; host_write = 1'b0; host_wdata = 48'd0;
        dev_irq = 2'b00; ifs = 48'd0; iec = {48{1'b1}}; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", |{cpu_vec, cpu_vec_valid, host_rdata, host_done, pic_addr,
              pic_read, pic_write, pic_wdata, seq_err, spur_cnt}, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef IRQ_SYNC_EN
        dev_irq = 2'b10; #1 check("irq_pass_10", pic_irq, 2'b10);
        dev_irq = 2'b01; #1 check("irq_pass_01", pic_irq, 2'b01);
        dev_irq = 2'b00;
        @(negedge clk);
`endif

        // Normal entry: IFS[45] -> OFF 3.
        exp_pic(1'b1, 15'o0, 48'd0);
        exp_pic(1'b0, 15'o5, 48'd1 << 45);
        vec_q.push_back(6'd3);
        cpu_int_en = 1'b1;
        ifs = 48'd1 << 45;
        wait_vec_valid("entry");
        ifs = 48'd0;
        check("entry_spur", spur_cnt, 8'd0);
        ack_vec("entry");

        // Spurious: request vanishes before the OFF read completes.
        exp_pic(1'b1, 15'o0, 48'd0);
        ifs = 48'd1 << 10;
        @(negedge clk);
        ifs = 48'd0;
        repeat (3) @(negedge clk);
        check("spur_cnt_inc", spur_cnt, 8'd1);
        check("spur_no_vec", cpu_vec_valid, 1'b0);

        // Tie with rr=HOST: host IEC read first, then sequence.
        exp_pic(1'b1, 15'o4, 48'd0);
        exp_pic(1'b1, 15'o0, 48'd0);
        exp_pic(1'b0, 15'o5, 48'd1 << 47);
        host_q.push_back({48{1'b1}});
        vec_q.push_back(6'd1);
        host_addr = 15'o4; host_read = 1'b1; ifs = 48'd1 << 47;
        wait_host_done("tie1");
        host_read = 1'b0;
        wait_vec_valid("tie1");
        ifs = 48'd0;
        ack_vec("tie1");

        // Second tie goes to the sequencer; host is served during delivery.
        exp_pic(1'b1, 15'o0, 48'd0);
        exp_pic(1'b0, 15'o5, 48'd1);
        exp_pic(1'b1, 15'o4, 48'd0);
        host_q.push_back({48{1'b1}});
        vec_q.push_back(6'd48);
        host_addr = 15'o4; host_read = 1'b1; ifs = 48'd1;
        wait_vec_valid("tie2");
        ifs = 48'd0;
        wait_host_done("tie2");
        host_read = 1'b0;
        check("tie2_vec_still_valid", cpu_vec_valid, 1'b1);
        ack_vec("tie2");

        // Sequencer timeout: no write issued, seq_err TIMEOUT cycles after the read strobe.
        stall = 1'b1;
        exp_pic(1'b1, 15'o0, 48'd0);
        err_q.push_back(TIMEOUT);
        ifs = 48'd1 << 20;
        @(negedge clk);
        cpu_int_en = 1'b0;
        begin
            int n = 0;
            while (!seq_err && n < 40) begin @(negedge clk); n++; end
            check("seq_timeout_seen", seq_err, 1'b1);
        end
        ifs = 48'd0;
        @(negedge clk);
        check("seq_err_pulse_len", seq_err, 1'b0);

        // Host timeout: host_done with zero data plus seq_err.
        exp_pic(1'b1, 15'o4, 48'd0);
        host_q.push_back(48'd0);
        err_q.push_back(TIMEOUT);
        host_addr = 15'o4; host_read = 1'b1;
        wait_host_done("host_to");
        host_read = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);

`ifdef IRQ_SYNC_EN
        begin
            int cnt = 0;
            int idx = 0;
            dev_irq = 2'b01;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (pic_irq[0]) begin cnt++; idx = i; end
            end
            dev_irq = 2'b00;
            check("sync_pulse_count", cnt, 1);
            check("sync_pulse_delay", idx, 3);
        end
`endif

        // Reset while in S_CLR: everything drops at once, no further strobes.
        cpu_int_en = 1'b1;
        exp_pic(1'b1, 15'o0, 48'd0);
        exp_pic(1'b0, 15'o5, 48'd1 << 40);
        ifs = 48'd1 << 40;
        begin
            int n = 0;
            while (!pic_write && n < 20) begin @(negedge clk); n++; end
            check("rst_write_seen", pic_write, 1'b1);
        end
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", |{cpu_vec, cpu_vec_valid, host_rdata, host_done, pic_addr,
                 pic_read, pic_write, pic_wdata, seq_err, spur_cnt}, 1'b0);
        cpu_int_en = 1'b0; ifs = 48'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_no_vec", cpu_vec_valid, 1'b0);
        exp_pic(1'b1, 15'o4, 48'd0);
        host_q.push_back({48{1'b1}});
        host_addr = 15'o4; host_read = 1'b1;
        wait_host_done("post_reset");
        host_read = 1'b0;
        repeat (4) @(negedge clk);

        check("pic_q_drained", pic_q.size(), 0);
        check("host_q_drained", host_q.size(), 0);
        check("vec_q_drained", vec_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
